// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8N1-style framing with configurable bit time and payload width.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send,
    output logic                 ready,
    output logic                 done,
    output logic                 tx
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CntLast);

    // tx is registered, so each branch loads the line value for the bit that starts next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (send) begin
                    state_d = StStart;
                    shift_d = data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BitLast) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = done_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl at CLK_DIV=4, DATA_BITS=8.
// Honours UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx_ctrl;

    localparam int unsigned Div = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned Par = 1;
`else
    localparam int unsigned Par = 0;
`endif
    localparam int unsigned FrameBits = 10 + Par;

    logic       clock = 1'b0;
    logic       reset_L;
    logic [7:0] data = 8'h00;
    logic       send = 1'b0;
    logic       ready, done, tx;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_tx_ctrl #(
        .CLK_DIV   (Div),
        .DATA_BITS (8)
    ) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .data    (data),
        .send    (send),
        .ready   (ready),
        .done    (done),
        .tx      (tx)
    );

    typedef struct {
        logic [7:0]  d;
        logic [10:0] seq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a list of line levels: start, payload LSB first, optional even parity, stop.
    function automatic logic [10:0] model_seq(input logic [7:0] d);
        bit          q[$];
        logic [10:0] s = '0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (Par != 0) q.push_back(bit'($countones(d) & 1));
        q.push_back(1'b1);
        foreach (q[i]) s[i] = q[i];
        return s;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge of the first idle cycle.
    task automatic run_frame(input logic [7:0] d, input logic [10:0] seq, input bit hold,
                             input bit disturb, input string tag);
        check({tag, ":ready_pre"}, ready, 1);
        data = d;
        send = 1'b1;
        @(posedge clock);
        for (int c = 0; c < int'(FrameBits * Div); c++) begin
            @(negedge clock);
            check($sformatf("%s:tx[%0d]", tag, c), tx, seq[c / Div]);
            check($sformatf("%s:ready[%0d]", tag, c), ready, 0);
            check($sformatf("%s:done[%0d]", tag, c), done, 0);
            if (!hold) begin
                if (disturb && c < int'(FrameBits * Div) - 1) begin
                    send = 1'($urandom_range(0, 1));
                    data = 8'($urandom);
                end else begin
                    send = 1'b0;
                end
            end
        end
        @(negedge clock);
        check({tag, ":idle_tx"}, tx, 1);
        check({tag, ":idle_ready"}, ready, 1);
        check({tag, ":idle_done"}, done, 1);
    endtask

    task automatic after_idle(input string tag);
        @(negedge clock);
        check({tag, ":post_done"}, done, 0);
        check({tag, ":post_ready"}, ready, 1);
        check({tag, ":post_tx"}, tx, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs.push_back('{8'hA5, 11'b1_0_1010_0101_0});
        vecs.push_back('{8'h07, 11'b1_1_0000_0111_0});
        vecs.push_back('{8'h3C, 11'b1_0_0011_1100_0});
`else
        vecs.push_back('{8'hA5, 11'b0_1_1010_0101_0});
        vecs.push_back('{8'h07, 11'b0_1_0000_0111_0});
        vecs.push_back('{8'h3C, 11'b0_1_0011_1100_0});
        vecs.push_back('{8'h00, 11'b0_1_0000_0000_0});
        vecs.push_back('{8'hFF, 11'b0_1_1111_1111_0});
`endif

        // Reset is checked before any clock edge to prove it is asynchronous.
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        #1;
        check("reset:tx", tx, 1);
        check("reset:ready", ready, 1);
        check("reset:done", done, 0);
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        check("release:tx", tx, 1);
        check("release:ready", ready, 1);
        check("release:done", done, 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].d, vecs[i].seq, 1'b0, 1'b0, $sformatf("vec%0d", i));
            after_idle($sformatf("vec%0d", i));
        end

        // Send pulses and data changes during a frame must be ignored.
        run_frame(8'h5A, model_seq(8'h5A), 1'b0, 1'b1, "disturb");
        for (int k = 0; k < int'(2 * Div); k++) begin
            @(negedge clock);
            check($sformatf("disturb:no2nd_tx[%0d]", k), tx, 1);
            check($sformatf("disturb:no2nd_ready[%0d]", k), ready, 1);
        end

        // Back-to-back with send held: the single idle cycle doubles as the next accept.
        run_frame(8'h00, model_seq(8'h00), 1'b1, 1'b0, "b2b0");
        run_frame(8'hFF, model_seq(8'hFF), 1'b0, 1'b0, "b2b1");
        after_idle("b2b1");

        // Reset in the middle of data bit 3 (cycle 17 of the frame).
        data = 8'hA5;
        send = 1'b1;
        @(posedge clock);
        @(negedge clock);
        send = 1'b0;
        repeat (17) @(negedge clock);
        check("midrst:tx_before", tx, 0);
        check("midrst:ready_before", ready, 0);
        #2 reset_L = 1'b0;
        #1;
        check("midrst:tx", tx, 1);
        check("midrst:ready", ready, 1);
        check("midrst:done", done, 0);
        repeat (2) @(negedge clock);
        check("midrst:hold_tx", tx, 1);
        reset_L = 1'b1;
        @(negedge clock);
        run_frame(8'h3C, model_seq(8'h3C), 1'b0, 1'b0, "postrst");
        after_idle("postrst");

        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            int         gap;
            d   = 8'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                check($sformatf("rnd%0d:gap_tx", n), tx, 1);
                check($sformatf("rnd%0d:gap_ready", n), ready, 1);
            end
            run_frame(d, model_seq(d), 1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
            after_idle($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
